// File: rtl/prog_loader.sv
// prog_loader
// -----------
// Byte-stream program loader and execution controller for the MIPS core.
// Bytes arriving on RX_DATA/RX_VALID are packed MSB-first into DATA_W-bit
// instruction words. Each completed word is presented on the memory write
// port (INSTR_OUT/INSTR_ADDR/INSTR_WE) at the next sequential address.
// Loading ends on the END_WORD sentinel (which is itself written) or when
// DEPTH words have been written without a sentinel (OVERFLOW). After that
// the block drives the pipeline advance enable FLAG_STEP, either
// continuously (MODE_CONT=1) or one pulse per STEP_REQ rising edge.
//
// Ports
//   CLK         rising-edge clock
//   RESET       asynchronous active-low reset
//   RX_DATA     incoming byte
//   RX_VALID    one-cycle strobe, RX_DATA valid
//   RELOAD      synchronous restart of the load sequence (beats RX_VALID)
//   MODE_CONT   1 = continuous run, 0 = single-step
//   STEP_REQ    step request level, acted on at its rising edge
//   INSTR_OUT   assembled word
//   INSTR_ADDR  write address
//   INSTR_WE    one-cycle write strobe
//   FLAG_I      high while loading
//   FLAG_STEP   pipeline advance enable
//   LOAD_DONE   high while running
//   WORD_COUNT  number of words written in this load sequence
//   OVERFLOW    sticky, memory filled without a sentinel

module prog_loader #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter logic [DATA_W-1:0] END_WORD = 32'hFFFFFFFF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [BYTE_W-1:0] RX_DATA,
  input  logic              RX_VALID,
  input  logic              RELOAD,
  input  logic              MODE_CONT,
  input  logic              STEP_REQ,
  output logic [DATA_W-1:0] INSTR_OUT,
  output logic [ADDR_W-1:0] INSTR_ADDR,
  output logic              INSTR_WE,
  output logic              FLAG_I,
  output logic              FLAG_STEP,
  output logic              LOAD_DONE,
  output logic [ADDR_W:0]   WORD_COUNT,
  output logic              OVERFLOW
);

  localparam int BYTES = DATA_W / BYTE_W;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(BYTES - 1);
  // Count value held while the final memory slot is being written.
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_reg,    state_next;
  logic [BC_W-1:0]   byte_cnt_reg, byte_cnt_next;
  logic [DATA_W-1:0] word_reg,     word_next;
  logic [DATA_W-1:0] instr_reg,    instr_next;
  logic [ADDR_W-1:0] addr_reg,     addr_next;
  logic              we_reg,       we_next;
  logic [CNT_W-1:0]  count_reg,    count_next;
  logic              ovf_reg,      ovf_next;
  logic              step_reg,     step_next;
  logic              prev_reg,     prev_next;
  logic              flag_i_reg,   flag_i_next;
  logic              done_reg,     done_next;

  // Shifting left by one symbol per byte leaves the first byte of a word in
  // the top bits once all BYTES symbols have arrived.
  logic [DATA_W-1:0] assembled;
  assign assembled = (word_reg << BYTE_W) | DATA_W'(RX_DATA);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg    <= LOAD;
      byte_cnt_reg <= '0;
      word_reg     <= '0;
      instr_reg    <= '0;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
      step_reg     <= 1'b0;
      prev_reg     <= 1'b0;
      flag_i_reg   <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      word_reg     <= word_next;
      instr_reg    <= instr_next;
      addr_reg     <= addr_next;
      we_reg       <= we_next;
      count_reg    <= count_next;
      ovf_reg      <= ovf_next;
      step_reg     <= step_next;
      prev_reg     <= prev_next;
      flag_i_reg   <= flag_i_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    word_next     = word_reg;
    instr_next    = instr_reg;
    addr_next     = addr_reg;
    we_next       = 1'b0;
    count_next    = count_reg;
    ovf_next      = ovf_reg;
    step_next     = 1'b0;
    prev_next     = prev_reg;

    if (RELOAD) begin
      // Restart from scratch; a byte arriving in the same cycle is dropped.
      state_next    = LOAD;
      byte_cnt_next = '0;
      word_next     = '0;
      count_next    = '0;
      ovf_next      = 1'b0;
      prev_next     = 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          prev_next = 1'b0;
          if (RX_VALID) begin
            word_next = assembled;
            if (byte_cnt_reg == LAST_BYTE) begin
              byte_cnt_next = '0;
              instr_next    = assembled;
              addr_next     = count_reg[ADDR_W-1:0];
              we_next       = 1'b1;
              count_next    = count_reg + 1'b1;
              if (assembled == END_WORD) begin
                state_next = RUN;
              end else if (count_reg == LAST_SLOT) begin
                ovf_next   = 1'b1;
                state_next = RUN;
              end
            end else begin
              byte_cnt_next = byte_cnt_reg + 1'b1;
            end
          end
        end
        RUN: begin
          // MODE_CONT is looked at every cycle so a mode switch acts at once.
          prev_next = STEP_REQ;
          step_next = MODE_CONT | (STEP_REQ & ~prev_reg);
        end
        default: begin
          state_next = LOAD;
        end
      endcase
    end

    // Status flags are registered copies of the upcoming state, so they
    // change in the same cycle as the final write strobe.
    flag_i_next = (state_next == LOAD);
    done_next   = (state_next == RUN);
  end

  assign INSTR_OUT  = instr_reg;
  assign INSTR_ADDR = addr_reg;
  assign INSTR_WE   = we_reg;
  assign FLAG_I     = flag_i_reg;
  assign FLAG_STEP  = step_reg;
  assign LOAD_DONE  = done_reg;
  assign WORD_COUNT = count_reg;
  assign OVERFLOW   = ovf_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: two instances (default geometry and a 4-word
// memory) share one stimulus stream. A reference model tracks each instance
// from the loader rules, queues expected writes, and a negedge monitor
// compares writes and status flags against it.

module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid, reload, mode_cont, step_req;

  logic [31:0] a_instr;  logic [5:0] a_addr;  logic [6:0] a_wc;
  logic a_we, a_fi, a_fs, a_done, a_ovf;
  logic [31:0] b_instr;  logic [1:0] b_addr;  logic [2:0] b_wc;
  logic b_we, b_fi, b_fs, b_done, b_ovf;

  prog_loader dut_a (
    .CLK(clk), .RESET(rst_n), .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .RELOAD(reload), .MODE_CONT(mode_cont), .STEP_REQ(step_req),
    .INSTR_OUT(a_instr), .INSTR_ADDR(a_addr), .INSTR_WE(a_we),
    .FLAG_I(a_fi), .FLAG_STEP(a_fs), .LOAD_DONE(a_done),
    .WORD_COUNT(a_wc), .OVERFLOW(a_ovf)
  );

  prog_loader #(.DEPTH(4), .ADDR_W(2)) dut_b (
    .CLK(clk), .RESET(rst_n), .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .RELOAD(reload), .MODE_CONT(mode_cont), .STEP_REQ(step_req),
    .INSTR_OUT(b_instr), .INSTR_ADDR(b_addr), .INSTR_WE(b_we),
    .FLAG_I(b_fi), .FLAG_STEP(b_fs), .LOAD_DONE(b_done),
    .WORD_COUNT(b_wc), .OVERFLOW(b_ovf)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int m_load[2], m_nb[2], m_count[2], m_ovf[2], m_step[2], m_prev[2], m_fi[2], m_done[2];
  logic [31:0] m_acc[2];
  logic [63:0] wq0[$];
  logic [63:0] wq1[$];

  task automatic model_reset(input int i);
    m_load[i] = 1; m_nb[i] = 0; m_count[i] = 0; m_ovf[i] = 0;
    m_step[i] = 0; m_prev[i] = 0; m_fi[i] = 0; m_done[i] = 0; m_acc[i] = '0;
  endtask

  task automatic model_edge(input int i, input int depth);
    logic [63:0] entry;
    if (reload) begin
      m_load[i] = 1; m_nb[i] = 0; m_acc[i] = '0; m_count[i] = 0;
      m_ovf[i] = 0; m_step[i] = 0; m_prev[i] = 0;
    end else if (m_load[i] != 0) begin
      m_step[i] = 0; m_prev[i] = 0;
      if (rx_valid) begin
        m_acc[i] = m_acc[i] * 256 + 32'(rx_data);
        m_nb[i]++;
        if (m_nb[i] == 4) begin
          m_nb[i] = 0;
          entry = {32'(m_count[i]), m_acc[i]};
          if (i == 0) wq0.push_back(entry); else wq1.push_back(entry);
          m_count[i]++;
          if (m_acc[i] == 32'hFFFFFFFF) m_load[i] = 0;
          else if (m_count[i] == depth) begin m_ovf[i] = 1; m_load[i] = 0; end
        end
      end
    end else begin
      m_step[i] = (mode_cont || (step_req && m_prev[i] == 0)) ? 1 : 0;
      m_prev[i] = step_req ? 1 : 0;
    end
    m_fi[i]   = m_load[i];
    m_done[i] = (m_load[i] == 0) ? 1 : 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0); model_reset(1);
    end else begin
      model_edge(0, 64); model_edge(1, 4);
    end
  end

  // ---------------- monitor ----------------
  int pulses_a = 0;
  int writes_b = 0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (a_we === 1'b1) begin
      if (wq0.size() == 0) check("a_unexpected_write", 1, 0);
      else begin
        e = wq0.pop_front();
        check("a_write_addr", 64'(a_addr), 64'(e[63:32]));
        check("a_write_data", 64'(a_instr), 64'(e[31:0]));
        $display("a write addr %0d data %08h", a_addr, a_instr);
      end
    end
    if (b_we === 1'b1) begin
      writes_b++;
      if (wq1.size() == 0) check("b_unexpected_write", 1, 0);
      else begin
        e = wq1.pop_front();
        check("b_write_addr", 64'(b_addr), 64'(e[63:32]));
        check("b_write_data", 64'(b_instr), 64'(e[31:0]));
        $display("b write addr %0d data %08h", b_addr, b_instr);
      end
    end
    if (a_fs === 1'b1) pulses_a++;
    check("a_flag_i",     64'(a_fi),   64'(m_fi[0]));
    check("a_flag_step",  64'(a_fs),   64'(m_step[0]));
    check("a_load_done",  64'(a_done), 64'(m_done[0]));
    check("a_word_count", 64'(a_wc),   64'(m_count[0]));
    check("a_overflow",   64'(a_ovf),  64'(m_ovf[0]));
    check("b_flag_i",     64'(b_fi),   64'(m_fi[1]));
    check("b_flag_step",  64'(b_fs),   64'(m_step[1]));
    check("b_load_done",  64'(b_done), 64'(m_done[1]));
    check("b_word_count", 64'(b_wc),   64'(m_count[1]));
    check("b_overflow",   64'(b_ovf),  64'(m_ovf[1]));
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
  endtask

  initial begin
    int p0, w0;
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; reload = 1'b0;
    mode_cont = 1'b1; step_req = 1'b0;
    idle(3);
    check("reset_flag_i", 64'(a_fi), 0);
    check("reset_we", 64'(a_we), 0);
    check("reset_instr", 64'(a_instr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("flag_i_after_release", 64'(a_fi), 1);

    // Default load ending on the sentinel, continuous mode.
    send_word(32'h20080005);
    send_word(32'h20090003);
    send_word(32'hFFFFFFFF);
    check("load_done_with_last_we", 64'(a_done), 1);
    check("flag_i_fell", 64'(a_fi), 0);
    check("last_we_addr", 64'(a_addr), 2);
    check("word_count_3", 64'(a_wc), 3);
    check("no_overflow", 64'(a_ovf), 0);
    check("step_not_yet", 64'(a_fs), 0);
    @(negedge clk);
    check("cont_step_high", 64'(a_fs), 1);
    mode_cont = 1'b0;
    @(negedge clk);
    check("cont_to_step_low", 64'(a_fs), 0);

    // Single-step: long hold gives one pulse, three short pulses give three.
    p0 = pulses_a;
    step_req = 1'b1; idle(10); step_req = 1'b0; idle(3);
    check("hold_one_pulse", 64'(pulses_a - p0), 1);
    p0 = pulses_a;
    for (int k = 0; k < 3; k++) begin
      step_req = 1'b1; idle(2); step_req = 1'b0; idle(3);
    end
    check("three_pulses", 64'(pulses_a - p0), 3);

    // RELOAD in RUN with a colliding byte.
    reload = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
    @(negedge clk);
    reload = 1'b0; rx_valid = 1'b0;
    check("reload_flag_i", 64'(a_fi), 1);
    check("reload_word_count", 64'(a_wc), 0);
    check("reload_overflow", 64'(a_ovf), 0);
    send_word($urandom);
    idle(2);
    check("after_reload_addr0", 64'(a_addr), 0);
    check("after_reload_count", 64'(a_wc), 1);

    // Overflow on the 4-word instance.
    reload = 1'b1; @(negedge clk); reload = 1'b0;
    w0 = writes_b;
    for (int k = 0; k < 5; k++) send_word({1'b0, 31'($urandom)});
    idle(2);
    check("ovf_writes", 64'(writes_b - w0), 4);
    check("ovf_flag", 64'(b_ovf), 1);
    check("ovf_count", 64'(b_wc), 4);
    check("ovf_done", 64'(b_done), 1);
    check("big_count_5", 64'(a_wc), 5);
    check("big_no_ovf", 64'(a_ovf), 0);

    // Reset in the middle of a word.
    send_byte(8'hAA); send_byte(8'hBB);
    rst_n = 1'b0; idle(3);
    check("midreset_count", 64'(a_wc), 0);
    rst_n = 1'b1;
    send_word(32'h11223344);
    idle(2);
    check("midreset_data", 64'(a_instr), 64'h11223344);
    check("midreset_addr", 64'(a_addr), 0);
    check("midreset_count_a", 64'(a_wc), 1);
    check("midreset_count_b", 64'(b_wc), 1);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      reload   = ($urandom_range(0, 59) == 0);
      rx_valid = ($urandom_range(0, 9) < 6);
      rx_data  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 39) == 0) mode_cont = ~mode_cont;
      if ($urandom_range(0, 3) == 0) step_req = ~step_req;
      @(negedge clk);
    end
    rst_n = 1'b1; reload = 1'b0; rx_valid = 1'b0;
    idle(5);
    check("a_writes_drained", 64'(wq0.size()), 0);
    check("b_writes_drained", 64'(wq1.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Synthesizable program loader and execution controller for the MIPS core. It replaces file-driven instruction injection with a byte-stream front end, for example from a UART receiver. Incoming bytes are assembled into instruction words and written sequentially into instruction memory. Once loading completes, the block drives the pipeline enable in continuous or single-step mode.

## Interface
Parameters:
- DATA_W, 32: instruction word width; must be a multiple of BYTE_W.
- BYTE_W, 8: width of one input symbol.
- DEPTH, 64: instruction memory depth in words.
- ADDR_W, 6: instruction address width; DEPTH <= 2^ADDR_W.
- END_WORD, 32'hFFFFFFFF: halt sentinel that terminates loading.

Ports:
- CLK, input, 1: single clock, rising edge.
- RESET, input, 1: asynchronous, active-low reset.
- RX_DATA, input, BYTE_W: incoming byte.
- RX_VALID, input, 1: RX_DATA valid this cycle; one-cycle strobe per byte.
- RELOAD, input, 1: synchronous restart of the load sequence.
- MODE_CONT, input, 1: 1 = continuous run, 0 = single-step.
- STEP_REQ, input, 1: step request, level; acted on at its rising edge.
- INSTR_OUT, output, DATA_W: assembled word.
- INSTR_ADDR, output, ADDR_W: write address.
- INSTR_WE, output, 1: one-cycle write strobe.
- FLAG_I, output, 1: high while in LOAD.
- FLAG_STEP, output, 1: pipeline advance enable.
- LOAD_DONE, output, 1: high in RUN.
- WORD_COUNT, output, ADDR_W+1: number of words written.
- OVERFLOW, output, 1: sticky; DEPTH reached without END_WORD.

## Operation
- Two states:
  - LOAD: reset state.
  - RUN.
- Word assembly:
  - BYTES = DATA_W/BYTE_W.
  - Order is MSB first: the first byte received lands in bits [DATA_W-1 -: BYTE_W].
  - An internal byte counter runs 0..BYTES-1 and wraps to 0 when a word completes.
- Word completion in LOAD:
  - The word is written at INSTR_ADDR = WORD_COUNT[ADDR_W-1:0].
  - WORD_COUNT then increments.
- Exit from LOAD:
  - Completed word == END_WORD: the word is written, then LOAD→RUN.
  - WORD_COUNT reaches DEPTH after a write that is not END_WORD: OVERFLOW←1, LOAD→RUN.
- RUN:
  - RX_VALID is ignored and no writes occur.
  - MODE_CONT=1: FLAG_STEP=1 continuously.
  - MODE_CONT=0: FLAG_STEP pulses high for exactly one cycle per 0→1 transition of STEP_REQ.
  - The STEP_REQ edge detector uses a registered previous value, which is cleared in LOAD.
  - MODE_CONT is re-evaluated every cycle, so a mode change takes effect immediately (see Timing).
- RELOAD:
  - In any state, returns to LOAD and clears the byte counter, WORD_COUNT, OVERFLOW, FLAG_STEP and the partial word.
  - RELOAD and RX_VALID in the same cycle: RELOAD wins and the byte is discarded.
- In LOAD, FLAG_STEP=0 and STEP_REQ edges are ignored.

## Timing
- Reset values (RESET low): all outputs 0, state LOAD, byte counter 0, edge-detect register 0. FLAG_I goes to 1 on the first clock after reset is released (it is registered).
- Write latency: last byte accepted at edge n → INSTR_OUT, INSTR_ADDR and INSTR_WE valid during cycle n+1. INSTR_WE is high for exactly one cycle.
- WORD_COUNT updates in the same cycle INSTR_WE is asserted.
- Entering RUN:
  - FLAG_I falls and LOAD_DONE rises in the same cycle as the final INSTR_WE.
  - FLAG_STEP (continuous mode) rises the following cycle.
- Step mode: STEP_REQ sampled high at edge k with previous sample low → FLAG_STEP high during cycle k+1 only.
- MODE_CONT 1→0 at edge k → FLAG_STEP low from cycle k+1.
- RESET asserted mid-word: the partial word is lost and the next byte after release is byte 0 of the word at address 0.
- Back-to-back RX_VALID on every cycle is supported at full rate, with no stall.

## Test plan
- Load with defaults: bytes 20 08 00 05, 20 09 00 03, FF FF FF FF → INSTR_WE pulses with (addr 0, 0x20080005), (addr 1, 0x20090003), (addr 2, 0xFFFFFFFF); WORD_COUNT=3; LOAD_DONE=1; OVERFLOW=0.
- Overflow with DEPTH=4, ADDR_W=2: five non-sentinel words → exactly 4 writes at addr 0..3; OVERFLOW=1; WORD_COUNT=4; the fifth word's bytes produce no write.
- Step mode: MODE_CONT=0, STEP_REQ held high 10 cycles → exactly one FLAG_STEP pulse; three separate 2-cycle STEP_REQ pulses → three FLAG_STEP pulses.
- Continuous mode: MODE_CONT=1 after load → FLAG_STEP=1 from the cycle after LOAD_DONE rises; MODE_CONT→0 → FLAG_STEP=0 the next cycle.
- Reset mid-word: bytes AA BB, then RESET low for 3 cycles, then 11 22 33 44 → single write at addr 0 of 0x11223344.
- RELOAD in RUN with RX_VALID in the same cycle (byte 0x55) → FLAG_I=1, WORD_COUNT=0, OVERFLOW=0; 0x55 is discarded; the next four bytes write addr 0.
